// File: rtl/rnn_accelerator_if.sv
// ---------------------------------------------------------------------------
// rnn_accelerator_if
// Bundles the sequence-level data bus of the RNN accelerator.
//   input_data  : whole input sequence x_0..x_{N-1}, Q8.8 signed
//   output_data : whole output sequence y_0..y_{N-1}, Q8.8 signed
//   done        : high once every output entry has been written
// master : sequence buffer / consumer side (drives input_data)
// slave  : accelerator side (drives output_data and done)
// ---------------------------------------------------------------------------
interface rnn_accelerator_if #(
    parameter int DATA_WIDTH      = 16,
    parameter int SEQUENCE_LENGTH = 32
);
    logic signed [DATA_WIDTH-1:0] input_data  [SEQUENCE_LENGTH];
    logic signed [DATA_WIDTH-1:0] output_data [SEQUENCE_LENGTH];
    logic                         done;

    modport master (
        output input_data,
        input  output_data,
        input  done
    );

    modport slave (
        input  input_data,
        output output_data,
        output done
    );
endinterface

// File: rtl/rnn_accelerator.sv
// ---------------------------------------------------------------------------
// rnn_accelerator
// Fixed-weight Elman recurrent cell in Q8.8. After reset release it evaluates
// one timestep per clock: every hidden unit does a combinational MAC of the
// current input and its own previous state, hard-tanh clamps the result to
// [-1.0, +1.0], and the floor mean of the new hidden vector is written into
// output_data[t]. done rises on the edge that writes the last entry.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset (clears h, t, outputs, done)
//   bus : slave modport of rnn_accelerator_if (input_data, output_data, done)
// ---------------------------------------------------------------------------
module rnn_accelerator #(
    parameter int                 DATA_WIDTH      = 16,
    parameter int                 HIDDEN_SIZE     = 64,
    parameter int                 SEQUENCE_LENGTH = 32,
    parameter logic signed [15:0] W_IN            = 16'sh0100,
    parameter logic signed [15:0] W_STEP          = 16'sh0000,
    parameter logic signed [15:0] W_REC           = 16'sh0080
) (
    input  logic              clk,
    input  logic              rst,
    rnn_accelerator_if.slave  bus
);
    localparam int LOG2_H = $clog2(HIDDEN_SIZE);
    localparam int SUM_W  = DATA_WIDTH + LOG2_H;
    localparam int IDX_W  = (SEQUENCE_LENGTH > 1) ? $clog2(SEQUENCE_LENGTH) : 1;
    localparam logic [IDX_W-1:0] T_LAST = IDX_W'(SEQUENCE_LENGTH - 1);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } state_t;

    state_t                       r_state;
    state_t                       w_state_next;
    logic                         w_run;
    logic [IDX_W-1:0]             r_t;
    logic                         r_done;
    logic signed [DATA_WIDTH-1:0] r_h      [HIDDEN_SIZE];
    logic signed [DATA_WIDTH-1:0] w_h_next [HIDDEN_SIZE];
    logic signed [DATA_WIDTH-1:0] r_out    [SEQUENCE_LENGTH];
    logic signed [DATA_WIDTH-1:0] w_x;
    logic signed [SUM_W-1:0]      w_sum;
    logic signed [DATA_WIDTH-1:0] w_y;

    // Hard-tanh: saturate the shifted MAC result to [-1.0, +1.0] in Q8.8.
    function automatic logic signed [15:0] f_hardtanh(input logic signed [32:0] p);
        if (p > 33'sd256) begin
            return 16'sh0100;
        end else if (p < -33'sd256) begin
            return 16'shFF00;
        end else begin
            return p[15:0];
        end
    endfunction

    // t never advances past the last index, so this read is always in range.
    assign w_x = bus.input_data[r_t];

    // One MAC per hidden unit; weights are elaboration-time constants.
    for (genvar j = 0; j < HIDDEN_SIZE; j++) begin : g_unit
        // Per-unit input weight wraps to 16 bits like the reference model.
        localparam logic signed [15:0] WX = 16'(W_IN + j * W_STEP);

        logic signed [31:0] w_a;
        logic signed [31:0] w_b;
        logic signed [32:0] w_s;

        assign w_a = 32'(WX) * 32'(w_x);
        assign w_b = 32'(W_REC) * 32'(r_h[j]);
        assign w_s = 33'(w_a) + 33'(w_b);
        // Arithmetic shift floors toward -inf, so -1 LSB persists.
        assign w_h_next[j] = f_hardtanh(w_s >>> 8);
    end

    // Floor mean of the freshly computed hidden vector.
    always_comb begin
        w_sum = '0;
        for (int j = 0; j < HIDDEN_SIZE; j++) begin
            w_sum = w_sum + SUM_W'(w_h_next[j]);
        end
        w_y = DATA_WIDTH'(w_sum >>> LOG2_H);
    end

    // Next-state logic: RUN until the last index is written, then DONE.
    always_comb begin
        w_state_next = r_state;
        w_run        = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_run = 1'b1;
                if (r_t == T_LAST) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_state_next = ST_RUN;
                end
            end
            ST_DONE: begin
                w_state_next = ST_DONE;
            end
            default: begin
                w_state_next = ST_RUN;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Datapath registers: hidden state, step counter, outputs, done flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_t    <= '0;
            r_done <= 1'b0;
            for (int j = 0; j < HIDDEN_SIZE; j++) begin
                r_h[j] <= '0;
            end
            for (int i = 0; i < SEQUENCE_LENGTH; i++) begin
                r_out[i] <= '0;
            end
        end else if (w_run) begin
            for (int j = 0; j < HIDDEN_SIZE; j++) begin
                r_h[j] <= w_h_next[j];
            end
            r_out[r_t] <= w_y;
            r_done     <= (w_state_next == ST_DONE);
            if (r_t != T_LAST) begin
                r_t <= r_t + IDX_W'(1);
            end
        end
    end

    assign bus.output_data = r_out;
    assign bus.done        = r_done;
endmodule

// File: tb/tb_rnn_accelerator.sv
// ---------------------------------------------------------------------------
// tb_rnn_accelerator
// Directed-vector bench for rnn_accelerator. dut_a uses default weights;
// dut_b uses a 4-unit spread configuration (W_IN=0, W_STEP=1.0, W_REC=0).
// Expected outputs are hand-derived Q8.8 values.
// ---------------------------------------------------------------------------
module tb_rnn_accelerator;
    localparam int N = 32;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;
    logic [15:0] exp_y [N];

    rnn_accelerator_if #(.DATA_WIDTH(16), .SEQUENCE_LENGTH(N)) if_a ();
    rnn_accelerator_if #(.DATA_WIDTH(16), .SEQUENCE_LENGTH(N)) if_b ();

    rnn_accelerator dut_a (
        .clk (clk),
        .rst (rst),
        .bus (if_a.slave)
    );

    rnn_accelerator #(
        .DATA_WIDTH      (16),
        .HIDDEN_SIZE     (4),
        .SEQUENCE_LENGTH (N),
        .W_IN            (16'sh0000),
        .W_STEP          (16'sh0100),
        .W_REC           (16'sh0000)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (if_b.slave)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic set_inputs(input logic [15:0] x0, input logic [15:0] xr);
        for (int i = 0; i < N; i++) begin
            if_a.input_data[i] = (i == 0) ? x0 : xr;
        end
    endtask

    // Hold reset for two edges, then release on a falling edge.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Reset, then step N edges checking written entry, next unwritten entry and done.
    task automatic run_and_check(input string name);
        do_reset();
        for (int k = 1; k <= N; k++) begin
            @(posedge clk);
            @(negedge clk);
            check_val($sformatf("%s y[%0d]", name, k - 1), 16'(if_a.output_data[k-1]), exp_y[k-1]);
            if (k < N) begin
                check_val($sformatf("%s unwritten y[%0d]", name, k), 16'(if_a.output_data[k]), 16'h0000);
            end
            check_val($sformatf("%s done@%0d", name, k), {15'd0, if_a.done}, {15'd0, (k == N)});
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        for (int i = 0; i < N; i++) begin
            if_b.input_data[i] = 16'sh0040;
        end

        // Reset state.
        set_inputs(16'h0040, 16'h0040);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("reset y[0]", 16'(if_a.output_data[0]), 16'h0000);
        check_val("reset y[31]", 16'(if_a.output_data[N-1]), 16'h0000);
        check_val("reset done", {15'd0, if_a.done}, 16'h0000);
        check_val("reset b done", {15'd0, if_b.done}, 16'h0000);

        // Constant 0.25: h = 64,96,112,120,124,126 then 127 (127.5 floors to 127).
        exp_y[0] = 16'h0040; exp_y[1] = 16'h0060; exp_y[2] = 16'h0070;
        exp_y[3] = 16'h0078; exp_y[4] = 16'h007C; exp_y[5] = 16'h007E;
        for (int i = 6; i < N; i++) exp_y[i] = 16'h007F;
        run_and_check("const");

        // Spread configuration ran alongside: mean of 0,64,128,192 = 96.
        check_val("spread y[0]", 16'(if_b.output_data[0]), 16'h0060);
        check_val("spread y[17]", 16'(if_b.output_data[17]), 16'h0060);
        check_val("spread y[31]", 16'(if_b.output_data[N-1]), 16'h0060);
        check_val("spread done", {15'd0, if_b.done}, 16'h0001);

        // DONE holds everything regardless of input changes.
        set_inputs(16'h0200, 16'h0200);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("hold y[0]", 16'(if_a.output_data[0]), 16'h0040);
        check_val("hold y[31]", 16'(if_a.output_data[N-1]), 16'h007F);
        check_val("hold done", {15'd0, if_a.done}, 16'h0001);

        // Mid-run reset after 10 run cycles clears written outputs.
        set_inputs(16'h0040, 16'h0040);
        do_reset();
        repeat (10) @(posedge clk);
        @(negedge clk);
        check_val("mid y[9]", 16'(if_a.output_data[9]), 16'h007F);
        check_val("mid y[10]", 16'(if_a.output_data[10]), 16'h0000);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_val("mid reset y[0]", 16'(if_a.output_data[0]), 16'h0000);
        check_val("mid reset y[9]", 16'(if_a.output_data[9]), 16'h0000);
        check_val("mid reset done", {15'd0, if_a.done}, 16'h0000);
        // Restart with constant input and re-check latency from t = 0.
        run_and_check("restart");

        // Impulse of 1.0 halves each step: 256>>t, zero from t = 9.
        set_inputs(16'h0100, 16'h0000);
        for (int i = 0; i < N; i++) exp_y[i] = (i <= 8) ? (16'h0100 >> i) : 16'h0000;
        run_and_check("impulse");

        // Positive saturation at +1.0.
        set_inputs(16'h0200, 16'h0200);
        for (int i = 0; i < N; i++) exp_y[i] = 16'h0100;
        run_and_check("satpos");

        // Negative saturation at -1.0.
        set_inputs(16'hFE00, 16'hFE00);
        for (int i = 0; i < N; i++) exp_y[i] = 16'hFF00;
        run_and_check("satneg");

        // -1 LSB survives the floor shift forever.
        set_inputs(16'hFFFF, 16'h0000);
        for (int i = 0; i < N; i++) exp_y[i] = 16'hFFFF;
        run_and_check("floor");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
